// File: rtl/regfile_param.sv
// Parametrised register file: registered dual read with write-first bypass,
// optional hard-wired zero register and a sequential sweep-clear engine.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              clr,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  output logic              rvalid,
  output logic              rd_ready,
  output logic              clr_busy
);

  localparam int unsigned        Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  LastIdx = ADDR_W'(Depth - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] bus_a_q, bus_a_d;
  logic [DATA_W-1:0] bus_b_q, bus_b_d;
  logic              rvalid_q, rvalid_d;

  logic              idle;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  assign idle  = (state_q == StIdle);
  assign wr_ok = en & we & idle & ~(ZERO_REG & (rd == '0));
  assign rd_ok = en & rd_en & idle;

  // Zero register wins over bypass; bypass wins over the stored value.
  always_comb begin
    if (ZERO_REG && (rs1 == '0)) begin
      rdata_a = '0;
    end else if (wr_ok && (rd == rs1)) begin
      rdata_a = data_in;
    end else begin
      rdata_a = regs_q[rs1];
    end
    if (ZERO_REG && (rs2 == '0)) begin
      rdata_b = '0;
    end else if (wr_ok && (rd == rs2)) begin
      rdata_b = data_in;
    end else begin
      rdata_b = regs_q[rs2];
    end
  end

  always_comb begin
    regs_d   = regs_q;
    state_d  = state_q;
    idx_d    = idx_q;
    bus_a_d  = bus_a_q;
    bus_b_d  = bus_b_q;
    rvalid_d = rd_ok;
    if (rd_ok) begin
      bus_a_d = rdata_a;
      bus_b_d = rdata_b;
    end
    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (wr_ok) begin
            regs_d[rd] = data_in;
          end
          if (clr) begin
            state_d = StSweep;
            idx_d   = '0;
          end
        end
        StSweep: begin
          regs_d[idx_q] = '0;
          idx_d         = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '{default: '0};
      state_q  <= StIdle;
      idx_q    <= '0;
      bus_a_q  <= '0;
      bus_b_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      bus_a_q  <= bus_a_d;
      bus_b_q  <= bus_b_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus_a    = bus_a_q;
  assign bus_b    = bus_b_q;
  assign rvalid   = rvalid_q;
  assign clr_busy = (state_q == StSweep);
  assign rd_ready = ~clr_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default instance checked against a behavioural model every cycle,
// plus a small ZERO_REG=0, 16-bit, 8-entry instance with directed checks.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, we, rd_en, clr;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] data_in;
  logic [31:0] bus_a, bus_b;
  logic        rvalid, rd_ready, clr_busy;

  logic        s_en, s_we, s_rd_en, s_clr;
  logic [2:0]  s_rd, s_rs1, s_rs2;
  logic [15:0] s_data_in, s_bus_a, s_bus_b;
  logic        s_rvalid, s_rd_ready, s_clr_busy;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mem [32];
  int          sweep_left;
  logic [31:0] exp_a, exp_b;
  logic        exp_v;
  int          cnt;

  always #5 clk = ~clk;

  regfile_param u_dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .rd(rd), .data_in(data_in),
    .rd_en(rd_en), .rs1(rs1), .rs2(rs2), .clr(clr), .bus_a(bus_a), .bus_b(bus_b),
    .rvalid(rvalid), .rd_ready(rd_ready), .clr_busy(clr_busy)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u_small (
    .clk(clk), .rst(rst), .en(s_en), .we(s_we), .rd(s_rd), .data_in(s_data_in),
    .rd_en(s_rd_en), .rs1(s_rs1), .rs2(s_rs2), .clr(s_clr), .bus_a(s_bus_a), .bus_b(s_bus_b),
    .rvalid(s_rvalid), .rd_ready(s_rd_ready), .clr_busy(s_clr_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    sweep_left = 0;
    exp_a = '0;
    exp_b = '0;
    exp_v = 1'b0;
  endtask

  // Behavioural effect of one rising edge on the default instance.
  task automatic model_edge();
    logic wr;
    exp_v = 1'b0;
    if (en) begin
      if (sweep_left == 0) begin
        wr = we && (rd != 5'd0);
        if (rd_en) begin
          exp_a = (rs1 == 5'd0) ? 32'd0 : (wr && rd == rs1) ? data_in : mem[rs1];
          exp_b = (rs2 == 5'd0) ? 32'd0 : (wr && rd == rs2) ? data_in : mem[rs2];
          exp_v = 1'b1;
        end
        if (wr) mem[rd] = data_in;
        if (clr) sweep_left = 32;
      end else begin
        mem[32 - sweep_left] = '0;
        sweep_left--;
      end
    end
  endtask

  task automatic check_all();
    chk("bus_a", bus_a, exp_a);
    chk("bus_b", bus_b, exp_b);
    chk("rvalid", {31'd0, rvalid}, {31'd0, exp_v});
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, sweep_left > 0});
    chk("rd_ready", {31'd0, rd_ready}, {31'd0, sweep_left == 0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_idle();
    en = 1'b1; we = 1'b0; rd = '0; data_in = '0; rd_en = 1'b0; rs1 = '0; rs2 = '0; clr = 1'b0;
    s_en = 1'b1; s_we = 1'b0; s_rd = '0; s_data_in = '0; s_rd_en = 1'b0;
    s_rs1 = '0; s_rs2 = '0; s_clr = 1'b0;
  endtask

  task automatic pulse_rst();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("s_clr_busy_rst", {31'd0, s_clr_busy}, 32'd0);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_main();
    for (int i = 0; i < 32; i++) begin
      set_idle();
      we = 1'b1; rd = 5'(i); data_in = 32'(i + 1);
      step();
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Read after reset
    rd_en = 1'b1; rs1 = 5'd5; rs2 = 5'd5;
    step();
    chk("r5_after_reset", bus_a, 32'd0);
    set_idle();
    step();

    // Write then read on the next cycle
    we = 1'b1; rd = 5'd7; data_in = 32'hDEADBEEF;
    step();
    set_idle();
    rd_en = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
    step();
    chk("r7_a", bus_a, 32'hDEADBEEF);
    chk("r7_b", bus_b, 32'hDEADBEEF);
    chk("r7_valid", {31'd0, rvalid}, 32'd1);

    // Same-cycle bypass
    set_idle();
    we = 1'b1; rd = 5'd9; data_in = 32'h12345678; rd_en = 1'b1; rs1 = 5'd9; rs2 = 5'd7;
    step();
    chk("bypass_a", bus_a, 32'h12345678);
    chk("bypass_b", bus_b, 32'hDEADBEEF);

    // Zero register
    set_idle();
    we = 1'b1; rd = 5'd0; data_in = 32'hFFFFFFFF;
    step();
    set_idle();
    rd_en = 1'b1; rs1 = 5'd0; rs2 = 5'd9;
    step();
    chk("r0_read", bus_a, 32'd0);
    set_idle();
    we = 1'b1; rd = 5'd0; data_in = 32'hFFFFFFFF; rd_en = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    step();
    chk("r0_bypass", bus_b, 32'd0);

    // Sweep clear with traffic that must be dropped
    fill_main();
    clr = 1'b1;
    step();
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      cnt++;
      set_idle();
      we = 1'b1; rd = 5'($urandom_range(1, 31)); data_in = $urandom;
      rd_en = 1'b1; rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      step();
    end
    chk("sweep_cycles", 32'(cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      set_idle();
      rd_en = 1'b1; rs1 = 5'(i); rs2 = 5'(31 - i);
      step();
      chk("after_sweep", bus_a | bus_b, 32'd0);
    end

    // Stall mid-sweep
    fill_main();
    clr = 1'b1;
    step();
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      set_idle();
      en = !(cnt >= 10 && cnt < 13);
      cnt++;
      step();
    end
    chk("stall_cycles", 32'(cnt), 32'd35);

    // Reset at sweep index 10
    fill_main();
    clr = 1'b1;
    step();
    set_idle();
    repeat (10) step();
    pulse_rst();
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1; rs1 = 5'(i); rs2 = 5'(i);
      step();
      chk("after_abort", bus_a, 32'd0);
    end

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      set_idle();
      en = ($urandom_range(0, 9) != 0);
      we = $urandom_range(0, 1) == 1;
      rd = 5'($urandom_range(0, 31));
      data_in = $urandom;
      rd_en = $urandom_range(0, 1) == 1;
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      clr = ($urandom_range(0, 49) == 0);
      step();
    end
    set_idle();
    while (sweep_left > 0) step();

    // Small instance: no zero register, 16-bit, 8 entries
    s_we = 1'b1; s_rd = 3'd0; s_data_in = 16'hFFFF;
    step();
    set_idle();
    s_rd_en = 1'b1; s_rs1 = 3'd0; s_rs2 = 3'd0;
    step();
    chk("s_r0", {16'd0, s_bus_a}, 32'h0000FFFF);
    chk("s_r0_valid", {31'd0, s_rvalid}, 32'd1);
    set_idle();
    s_we = 1'b1; s_rd = 3'd7; s_data_in = 16'hA5A5;
    step();
    set_idle();
    s_rd_en = 1'b1; s_rs1 = 3'd7; s_rs2 = 3'd0;
    step();
    chk("s_r7", {16'd0, s_bus_a}, 32'h0000A5A5);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        set_idle();
        s_we = 1'b1; s_rd = 3'(i); s_data_in = 16'(i + 1);
        step();
      end
      set_idle();
      s_clr = 1'b1;
      step();
      set_idle();
      cnt = 0;
      while (s_clr_busy && cnt < 50) begin
        cnt++;
        step();
      end
      chk("s_sweep_cycles", 32'(cnt), 32'd8);
      for (int i = 0; i < 8; i++) begin
        set_idle();
        s_rd_en = 1'b1; s_rs1 = 3'(i); s_rs2 = 3'(7 - i);
        step();
        chk("s_after_sweep", {16'd0, s_bus_a | s_bus_b}, 32'd0);
      end
    end
    set_idle();
    s_we = 1'b1; s_rd = 3'd3; s_data_in = 16'h1234;
    step();
    set_idle();
    s_rd_en = 1'b1; s_rs1 = 3'd3; s_rs2 = 3'd4;
    step();
    chk("s_post_sweep_a", {16'd0, s_bus_a}, 32'h00001234);
    chk("s_post_sweep_b", {16'd0, s_bus_b}, 32'd0);
    chk("s_idle_busy", {31'd0, s_clr_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the team's 32x32 register file. Depth, data width and zero-register behaviour are generic. Reads are registered and flagged with a valid strobe, with write-first bypass. A sequential clear engine sweeps the array to zero without an asynchronous reset. It sits between the decode stage and the ALU operand buses of the datapath.

## Interface
- DATA_W, 32, width of each register and of the data buses
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes
- clk  in  1  single clock, rising-edge active
- rst  in  1  reset, asynchronous and active-high
- en  in  1  global enable; when low the block freezes (no write, no read capture, sweep stalls)
- we  in  1  write request (write = 1)
- rd  in  ADDR_W  write address
- data_in  in  DATA_W  write data
- rd_en  in  1  read request for both read ports
- rs1  in  ADDR_W  read address, port A
- rs2  in  ADDR_W  read address, port B
- clr  in  1  start a sweep clear (single-cycle pulse)
- bus_a  out  DATA_W  registered read data, port A
- bus_b  out  DATA_W  registered read data, port B
- rvalid  out  1  bus_a/bus_b updated this cycle
- rd_ready  out  1  read/write port accepting requests (= !clr_busy)
- clr_busy  out  1  sweep clear in progress

## Operation
- Reset (rst high, asynchronous): all DEPTH registers go to 0, bus_a/bus_b = 0, rvalid = 0, clr_busy = 0, FSM = IDLE, sweep index = 0. Reset mid-sweep aborts the sweep immediately.
- Write: the write occurs at a rising edge when en & we & rd_ready. It is suppressed when ZERO_REG=1 and rd=0. A write while clr_busy is dropped silently.
- Read: the read is captured at a rising edge when en & rd_en & rd_ready.
  - bus_a gets reg[rs1] and bus_b gets reg[rs2].
  - rvalid = 1 for exactly that following cycle; otherwise rvalid = 0.
- Bypass: if a read and an accepted write hit the same address in the same cycle, the read returns data_in (write-first). Both ports bypass independently.
- Zero register: with ZERO_REG=1, a read of address 0 returns 0 regardless of bypass.
- Hold: bus_a/bus_b hold their last value when no read is captured. They are not cleared by the sweep.
- en low: nothing changes except rvalid, which is forced to 0 at the next edge.
- Clear FSM has two states, IDLE and SWEEP.
  - IDLE -> SWEEP: on en & clr. The sweep index is set to 0 and no other register is touched in that cycle.
  - Any we/rd_en presented in the same cycle as clr is still honoured.
  - SWEEP: each en-high edge writes 0 to reg[index] and increments index. When index = DEPTH-1, that write completes and the FSM returns to IDLE.
  - clr asserted during SWEEP is ignored (no restart).
  - clr_busy = 1 exactly while in SWEEP.
- The index counter is ADDR_W bits and wraps naturally. Termination uses the DEPTH-1 compare, never overflow.

## Timing
- Write-to-read latency: a write at edge N is visible to a read captured at edge N (via bypass) and at edge N+1 (from the array).
- Read latency is 1 cycle: request at edge N produces data and rvalid after edge N. Back-to-back reads give rvalid high on consecutive cycles.
- Clear duration: clr seen at edge N puts clr_busy high after N. It stays high for DEPTH en-high cycles and falls after edge N+DEPTH. rd_ready is high again in that same cycle.
- Stalled cycles (en low) during SWEEP extend clr_busy one-for-one.
- All outputs are registered or derived directly from FSM state. There is no combinational path from inputs to outputs.

## Test plan
- Reset: pulse rst between edges -> immediately bus_a = bus_b = 0, rvalid = 0, clr_busy = 0. Read of reg 5 after reset returns 0.
- Write/read and bypass:
  - Write 0xDEADBEEF to r7, then read rs1 = 7, rs2 = 7 next cycle -> both buses 0xDEADBEEF with rvalid one cycle later.
  - Same-cycle write 0x12345678 to r9 with read rs1 = 9 -> bus_a = 0x12345678.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0, then read r0 -> 0. Same-cycle write+read of r0 -> 0. With ZERO_REG=0 the same sequence returns 0xFFFFFFFF.
- Sweep clear: fill all 32 registers with their index+1, then pulse clr.
  - clr_busy stays high for exactly 32 cycles.
  - Writes and reads during the sweep are dropped and rvalid stays 0.
  - Afterwards every register reads 0.
- Stall and abort:
  - Drop en for 3 cycles mid-sweep -> clr_busy lasts 35 cycles.
  - Assert rst at sweep index 10 -> clr_busy falls immediately and all registers read 0.
- Parameter sweep: DATA_W=16, ADDR_W=3 -> clear takes 8 cycles, index wraps without overrun, and r7 write/read round-trips 0xA5A5.
